ifu_fetch: RTL and testbench



---
 rtl/ifu_fetch.sv | 151 +++++++++++++++
 tb/tb_ifu_fetch.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit for the single-cycle MIPS core.
// Holds the PC, fetches one word per step over a req/ready handshake,
// and presents the held instruction to the control decoder.
// Optional feature macro: IFU_ALIGN_CHECK_EN (word-aligns register targets
// and raises a sticky addr_err on a misaligned jr/jalr target).
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  NPCOp,
  input  logic [31:0] RA,
  input  logic        advance,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  Op,
  output logic [5:0]  Funct,
  output logic        addr_err
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned JIDX_W = 26;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              load_instr;
  logic              load_pc;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   pc4_q;
  logic [XLEN-1:0]   instr_q;
  logic              req_q;
  logic              valid_q;
  logic [XLEN-1:0]   npc;
  logic [XLEN-1:0]   pc_load;
  logic [XLEN-1:0]   br_off;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath load enables
  always_comb begin
    state_nxt  = state;
    load_instr = 1'b0;
    load_pc    = 1'b0;
    unique case (state)
      IDLE: begin
        state_nxt = FETCH;
      end
      FETCH: begin
        if (imem_ready) begin
          load_instr = 1'b1;
          state_nxt  = HOLD;
        end
      end
      HOLD: begin
        if (advance) begin
          load_pc   = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Next-PC select from held instruction, PC and rs value
  always_comb begin
    br_off = {{(XLEN-IMM_W-2){instr_q[IMM_W-1]}}, instr_q[IMM_W-1:0], 2'b00};
    npc    = pc4_q;
    unique case (NPCOp)
      2'b00:   npc = pc4_q;
      2'b01:   npc = pc4_q + br_off;
      2'b10:   npc = {pc4_q[XLEN-1:XLEN-4], instr_q[JIDX_W-1:0], 2'b00};
      2'b11:   npc = RA;
      default: npc = pc4_q;
    endcase
  end

`ifdef IFU_ALIGN_CHECK_EN
  logic misalign_c;

  // Register targets are forced onto a word boundary
  always_comb begin
    misalign_c = (NPCOp == 2'b11) && (RA[1:0] != 2'b00);
    pc_load    = misalign_c ? {npc[XLEN-1:2], 2'b00} : npc;
  end

  // Sticky misalignment flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_err <= 1'b0;
    end else if (load_pc && misalign_c) begin
      addr_err <= 1'b1;
    end
  end
`else
  assign pc_load  = npc;
  assign addr_err = 1'b0;
`endif

  // PC, instruction and handshake output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      pc4_q   <= RESET_PC + XLEN'(4);
      instr_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      req_q   <= (state_nxt == FETCH);
      valid_q <= (state_nxt == HOLD);
      if (load_instr) begin
        instr_q <= imem_rdata;
      end
      if (load_pc) begin
        pc_q  <= pc_load;
        pc4_q <= pc_load + XLEN'(4);
      end
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign PC          = pc_q;
  assign PC4         = pc4_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign Op          = instr_q[31:26];
  assign Funct       = instr_q[5:0];

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: scoreboard of expected fetch addresses
// and instruction words, compared when the DUT requests / presents them.
module tb_ifu_fetch;

  logic        clk;
  logic        rst;
  logic [1:0]  NPCOp;
  logic [31:0] RA;
  logic        advance;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] PC;
  logic [31:0] PC4;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  Op;
  logic [5:0]  Funct;
  logic        addr_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];
  logic [31:0] model_pc;
  logic [31:0] model_instr;
  logic        model_err;

  ifu_fetch #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst(rst), .NPCOp(NPCOp), .RA(RA), .advance(advance),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .imem_req(imem_req),
    .imem_addr(imem_addr), .PC(PC), .PC4(PC4), .instr(instr),
    .instr_valid(instr_valid), .Op(Op), .Funct(Funct), .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference next-PC
  function automatic logic [31:0] ref_npc(input logic [1:0] op, input logic [31:0] ra);
    logic [31:0] p4;
    logic [31:0] off;
    p4  = model_pc + 32'd4;
    off = 32'(signed'(model_instr[15:0])) << 2;
    case (op)
      2'b00:   return p4;
      2'b01:   return p4 + off;
      2'b10:   return {p4[31:28], model_instr[25:0], 2'b00};
      default: begin
`ifdef IFU_ALIGN_CHECK_EN
        return {ra[31:2], 2'b00};
`else
        return ra;
`endif
      end
    endcase
  endfunction

  // Pop the expected fetch address and compare against the request
  task automatic check_fetch_addr();
    if (exp_addr_q.size() == 0) begin
      check("addr_queue_empty", 32'd1, 32'd0);
    end else begin
      check("fetch_addr", imem_addr, exp_addr_q.pop_front());
    end
  endtask

  // Serve the outstanding fetch after 'stall' not-ready cycles
  task automatic serve(input logic [31:0] word, input int stall);
    check("req_in_fetch", 32'(imem_req), 32'd1);
    check_fetch_addr();
    for (int i = 0; i < stall; i++) begin
      NPCOp   = 2'b01;
      advance = 1'b1;
      tick();
      advance = 1'b0;
      check("stall_addr", imem_addr, model_pc);
      check("stall_pc", PC, model_pc);
      check("stall_valid", 32'(instr_valid), 32'd0);
      check("stall_req", 32'(imem_req), 32'd1);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    exp_instr_q.push_back(word);
    tick();
    imem_ready = 1'b0;
    imem_rdata = $urandom();
    model_instr = word;
    check("valid_rise", 32'(instr_valid), 32'd1);
    check("req_drop", 32'(imem_req), 32'd0);
    if (exp_instr_q.size() == 0) begin
      check("instr_queue_empty", 32'd1, 32'd0);
    end else begin
      check("instr", instr, exp_instr_q.pop_front());
    end
    check("op", 32'(Op), 32'(word[31:26]));
    check("funct", 32'(Funct), 32'(word[5:0]));
  endtask

  // Retire the held instruction with the given next-PC select
  task automatic step(input logic [1:0] op, input logic [31:0] ra);
    logic [31:0] nxt;
    nxt = ref_npc(op, ra);
`ifdef IFU_ALIGN_CHECK_EN
    if (op == 2'b11 && ra[1:0] != 2'b00) model_err = 1'b1;
`endif
    NPCOp   = op;
    RA      = ra;
    advance = 1'b1;
    tick();
    advance = 1'b0;
    model_pc = nxt;
    exp_addr_q.push_back(nxt);
    check("adv_valid", 32'(instr_valid), 32'd0);
    check("adv_req", 32'(imem_req), 32'd1);
    check("adv_pc", PC, model_pc);
    check("adv_pc4", PC4, model_pc + 32'd4);
    check("addr_err", 32'(addr_err), 32'(model_err));
  endtask

  initial begin
    rst        = 1'b1;
    NPCOp      = 2'b00;
    RA         = '0;
    advance    = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'h0109_5020;
    model_pc    = 32'h0000_3000;
    model_instr = '0;
    model_err   = 1'b0;

    // Reset held two cycles
    tick();
    tick();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc", PC, 32'h0000_3000);
    check("rst_instr", instr, 32'd0);
    check("rst_err", 32'(addr_err), 32'd0);

    // Boot bubble: advance in IDLE must be ignored
    rst        = 1'b0;
    imem_ready = 1'b0;
    advance    = 1'b1;
    exp_addr_q.push_back(32'h0000_3000);
    tick();
    advance = 1'b0;
    check("first_req", 32'(imem_req), 32'd1);
    check("first_valid", 32'(instr_valid), 32'd0);

    // First fetch: add
    serve(32'h0109_5020, 0);
    check("add_op", 32'(Op), 32'd0);
    check("add_funct", 32'(Funct), 32'h20);

    // Sequential steps up to 0x3010
    step(2'b00, 32'd0);
    serve(32'h0000_0000, 0);
    step(2'b00, 32'd0);
    serve(32'h0000_0000, 0);
    step(2'b00, 32'd0);
    serve(32'h0000_0000, 0);
    step(2'b00, 32'd0);
    check("seq_pc", PC, 32'h0000_3010);

    // Backward branch, imm16 = 0xFFFE
    serve(32'h1000_FFFE, 0);
    step(2'b01, 32'd0);
    check("branch_pc", PC, 32'h0000_300C);

    // Register target to 0x3020, then jump
    serve(32'h0000_0000, 0);
    step(2'b11, 32'h0000_3020);
    serve(32'h0800_0C04, 0);
    step(2'b10, 32'd0);
    check("jump_pc", PC, 32'h0000_3010);
    serve(32'h03E0_0008, 0);
    step(2'b11, 32'h0000_3100);
    check("jr_pc", PC, 32'h0000_3100);

    // Memory stall with advance pulses
    serve(32'h2108_0001, 5);

    // Wrap of PC+4
    step(2'b11, 32'hFFFF_FFFC);
    serve(32'h0000_0000, 2);
    step(2'b00, 32'd0);
    check("wrap_pc", PC, 32'h0000_0000);

    // Misaligned register target
    serve(32'h0000_0000, 0);
    step(2'b11, 32'h0000_3103);
`ifdef IFU_ALIGN_CHECK_EN
    check("mis_pc", PC, 32'h0000_3100);
    check("mis_err", 32'(addr_err), 32'd1);
`else
    check("mis_pc", PC, 32'h0000_3103);
    check("mis_err", 32'(addr_err), 32'd0);
`endif
    serve(32'h0000_0000, 1);
    step(2'b00, 32'd0);
    check("err_sticky", 32'(addr_err), 32'(model_err));

    // Reset mid-fetch; a late response is dropped
    check_fetch_addr();
    rst = 1'b1;
    tick();
    check("midrst_pc", PC, 32'h0000_3000);
    check("midrst_req", 32'(imem_req), 32'd0);
    check("midrst_err", 32'(addr_err), 32'd0);
    check("midrst_valid", 32'(instr_valid), 32'd0);
    rst        = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ready = 1'b0;
    check("late_valid", 32'(instr_valid), 32'd0);
    check("late_req", 32'(imem_req), 32'd1);
    check("late_instr", instr, 32'd0);
    model_pc  = 32'h0000_3000;
    model_err = 1'b0;
    exp_addr_q.push_back(32'h0000_3000);
    serve(32'h0109_5020, 0);

    check("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
